// File: rtl/barcode_frame_serializer_pkg.sv
// Shared constants and FSM encoding for the barcode frame serializer.
// No ports.
package barcode_frame_serializer_pkg;

  localparam int DIGIT_W    = 4;
  localparam int DIGIT_BC_W = 11;
  localparam int GUARD_W    = 3;
  localparam logic [2:0] GUARD_PAT = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    GUARD_S,
    DATA,
    GUARD_E
  } state_t;

endpackage

// File: rtl/barcode_frame_serializer_if.sv
// Frame-in handshake plus bar-out stream bundle.
// master: digit source / bar sink; slave: serializer.
interface barcode_frame_serializer_if #(
  parameter int DIGITS = 4
);
  import barcode_frame_serializer_pkg::*;

  logic                      in_valid;
  logic                      in_ready;
  logic [DIGITS*DIGIT_W-1:0] digits;
  logic                      stall;
  logic                      bar_out;
  logic                      bar_valid;
  logic                      frame_start;
  logic                      frame_end;
  logic                      busy;

  modport master (
    output in_valid, digits, stall,
    input  in_ready, bar_out, bar_valid,
    input  frame_start, frame_end, busy
  );

  modport slave (
    input  in_valid, digits, stall,
    output in_ready, bar_out, bar_valid,
    output frame_start, frame_end, busy
  );

endinterface

// File: rtl/barcode_frame_serializer_enc.sv
// Combinational digit -> 11-bit bar pattern (MSB sent first).
// Ports: digit (4b in), pat (11b out).
module barcode_frame_serializer_enc (
  input  logic [3:0]  digit,
  output logic [10:0] pat
);

  assign pat = {2'b10,
                digit[3], ~digit[3],
                digit[2], ~digit[2],
                digit[1], ~digit[1],
                digit[0], ~digit[0],
                1'b0};

endmodule

// File: rtl/barcode_frame_serializer.sv
// Serialises a digit frame into a 1-bit/clk barcode with guards/checksum.
// Ports: clk, rst (async high), bus (slave: frame in, bar stream out).
module barcode_frame_serializer #(
  parameter int DIGITS    = 4,
  parameter bit GUARD_EN  = 1'b1,
  parameter bit CHKSUM_EN = 1'b1
) (
  input logic clk,
  input logic rst,
  barcode_frame_serializer_if.slave bus
);
  import barcode_frame_serializer_pkg::*;

  localparam int NDIG = DIGITS + int'(CHKSUM_EN);
  localparam int FW   = DIGITS * DIGIT_W;

  state_t       state, nstate;
  logic [3:0]   bit_cnt, nbit;
  logic [4:0]   dig_cnt, ndig;
  logic [FW-1:0] frame_q, fsrc;
  logic [3:0]   chk_q, chk_in, csrc, dsel;
  logic [10:0]  pat;
  logic         bo_q, bv_q, fs_q, fe_q;
  logic         rdy, acc, adv, upd;
  logic         nbo, nfe;

  // State/counters always describe the bit currently on bar_out.
  assign rdy = (state == IDLE) | (fe_q & ~bus.stall);
  assign acc = bus.in_valid & rdy;
  assign adv = bv_q & ~bus.stall;
  assign upd = acc | adv;

  always_comb begin
    chk_in = '0;
    for (int i = 0; i < DIGITS; i++)
      chk_in = chk_in + bus.digits[i*DIGIT_W +: DIGIT_W];
  end

  always_comb begin
    nstate = state;
    nbit   = bit_cnt;
    ndig   = dig_cnt;
    if (acc) begin
      nstate = GUARD_EN ? GUARD_S : DATA;
      nbit   = GUARD_EN ? 4'(GUARD_W-1) : 4'(DIGIT_BC_W-1);
      ndig   = '0;
    end else if (adv && fe_q) begin
      nstate = IDLE;
      nbit   = '0;
      ndig   = '0;
    end else if (adv) begin
      unique case (state)
        GUARD_S: begin
          if (bit_cnt == 4'd0) begin
            nstate = DATA;
            nbit   = 4'(DIGIT_BC_W-1);
          end else begin
            nbit = bit_cnt - 4'd1;
          end
        end
        DATA: begin
          if (bit_cnt != 4'd0) begin
            nbit = bit_cnt - 4'd1;
          end else if (dig_cnt == 5'(NDIG-1)) begin
            nstate = GUARD_E;
            nbit   = 4'(GUARD_W-1);
          end else begin
            ndig = dig_cnt + 5'd1;
            nbit = 4'(DIGIT_BC_W-1);
          end
        end
        GUARD_E: nbit = bit_cnt - 4'd1;
        default: ;
      endcase
    end
  end

  // On accept the frame is still on the bus, so select from it directly.
  always_comb begin
    fsrc = acc ? bus.digits : frame_q;
    csrc = acc ? chk_in : chk_q;
    dsel = '0;
    for (int i = 0; i < DIGITS; i++)
      if (ndig == 5'(i))
        dsel = fsrc[(DIGITS-1-i)*DIGIT_W +: DIGIT_W];
    if (CHKSUM_EN && ndig == 5'(DIGITS))
      dsel = csrc;
  end

  barcode_frame_serializer_enc u_enc (
    .digit (dsel),
    .pat   (pat)
  );

  always_comb begin
    nbo = 1'b0;
    unique case (nstate)
      GUARD_S, GUARD_E: nbo = GUARD_PAT[nbit[1:0]];
      DATA:             nbo = pat[nbit];
      default:          nbo = 1'b0;
    endcase
    if (GUARD_EN)
      nfe = (nstate == GUARD_E) && (nbit == 4'd0);
    else
      nfe = (nstate == DATA) && (nbit == 4'd0)
            && (ndig == 5'(NDIG-1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      dig_cnt <= '0;
      frame_q <= '0;
      chk_q   <= '0;
      bo_q    <= 1'b0;
      bv_q    <= 1'b0;
      fs_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else if (upd) begin
      state   <= nstate;
      bit_cnt <= nbit;
      dig_cnt <= ndig;
      bo_q    <= nbo;
      bv_q    <= (nstate != IDLE);
      fs_q    <= acc;
      fe_q    <= nfe;
      if (acc) begin
        frame_q <= bus.digits;
        chk_q   <= chk_in;
      end
    end
  end

  assign bus.in_ready    = rdy;
  assign bus.bar_out     = bo_q;
  assign bus.bar_valid   = bv_q;
  assign bus.frame_start = fs_q;
  assign bus.frame_end   = fe_q;
  assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_barcode_frame_serializer.sv
// Directed bench for barcode_frame_serializer.
// Two instances: default config and DIGITS=1 without guard/checksum.
module tb_barcode_frame_serializer;

  logic clk = 1'b0;
  logic rst;
  int   n_run  = 0;
  int   n_fail = 0;

  localparam logic [63:0] F1234 = 64'({
    3'b101,
    11'b10010101100,
    11'b10010110010,
    11'b10010110100,
    11'b10011001010,
    11'b10100110010,
    3'b101});

  localparam logic [63:0] F9999 = 64'({
    3'b101,
    11'b10100101100,
    11'b10100101100,
    11'b10100101100,
    11'b10100101100,
    11'b10011001010,
    3'b101});

  barcode_frame_serializer_if #(.DIGITS(4)) bf ();
  barcode_frame_serializer_if #(.DIGITS(1)) b1 ();

  barcode_frame_serializer #(
    .DIGITS(4), .GUARD_EN(1'b1), .CHKSUM_EN(1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bf.slave)
  );

  barcode_frame_serializer #(
    .DIGITS(1), .GUARD_EN(1'b0), .CHKSUM_EN(1'b0)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [15:0] d);
    bf.digits   = d;
    bf.in_valid = 1'b1;
    step();
    bf.in_valid = 1'b0;
  endtask

  // ev_kind 1: 5-cycle stall at bit ev_at; 2: FFFF pulse at bit ev_at
  task automatic collect(input  int          ev_at,
                         input  int          ev_kind,
                         output logic [63:0] v,
                         output int          n,
                         output int          fe_idx,
                         output logic        fs0);
    bit done;
    int kind;
    logic bo;
    v = '0; n = 0; fe_idx = -1; fs0 = 1'b0;
    done = 1'b0; kind = ev_kind;
    for (int c = 0; c < 400 && !done; c++) begin
      if (kind == 1 && n == ev_at) begin
        bo = bf.bar_out;
        bf.stall = 1'b1;
        kind = 0;
        repeat (5) begin
          step();
          chk("t4_stall_valid", 64'(bf.bar_valid), 1);
          chk("t4_stall_bit", 64'(bf.bar_out), 64'(bo));
        end
        bf.stall = 1'b0;
      end
      if (kind == 2 && n == ev_at) begin
        bf.in_valid = 1'b1;
        bf.digits   = 16'hFFFF;
        kind = 3;
      end else if (kind == 3) begin
        bf.in_valid = 1'b0;
        kind = 0;
      end
      if (bf.bar_valid) begin
        v = {v[62:0], bf.bar_out};
        if (n == 0) fs0 = bf.frame_start;
        if (bf.frame_end) begin
          fe_idx = n;
          done = 1'b1;
        end
        n++;
      end
      step();
    end
  endtask

  logic [63:0] v;
  int          n, fe;
  logic        fs;

  initial begin
    rst = 1'b1;
    bf.in_valid = 1'b0; bf.digits = '0; bf.stall = 1'b0;
    b1.in_valid = 1'b0; b1.digits = '0; b1.stall = 1'b0;
    #2;
    chk("rst_valid", 64'(bf.bar_valid), 0);
    chk("rst_bar", 64'(bf.bar_out), 0);
    chk("rst_busy", 64'(bf.busy), 0);
    chk("rst_ready", 64'(bf.in_ready), 1);
    chk("rst_fse", 64'({bf.frame_start, bf.frame_end}), 0);
    chk("rst_ready1", 64'(b1.in_ready), 1);
    step();
    step();
    rst = 1'b0;

    // T1: single digit 0x5, no guard, no checksum
    b1.digits = 4'h5;
    b1.in_valid = 1'b1;
    step();
    b1.in_valid = 1'b0;
    v = '0; n = 0; fe = -1; fs = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (b1.bar_valid) begin
        v = {v[62:0], b1.bar_out};
        if (n == 0) fs = b1.frame_start;
        if (b1.frame_end) fe = n;
        n++;
      end
      step();
    end
    chk("t1_len", 64'(n), 11);
    chk("t1_bits", v, 64'h4CC);
    chk("t1_start", 64'(fs), 1);
    chk("t1_end", 64'(fe), 10);

    // T2: 1234 with guards and checksum 0xA
    start(16'h1234);
    chk("t2_lat", 64'(bf.bar_valid), 1);
    collect(-1, 0, v, n, fe, fs);
    chk("t2_bits", v, F1234);
    chk("t2_len", 64'(n), 61);
    chk("t2_start", 64'(fs), 1);
    chk("t2_end", 64'(fe), 60);
    chk("t2_idle_valid", 64'(bf.bar_valid), 0);
    chk("t2_idle_busy", 64'(bf.busy), 0);
    chk("t2_idle_ready", 64'(bf.in_ready), 1);

    // T3: 9999 checksum wrap, back-to-back frames
    bf.digits = 16'h9999;
    bf.in_valid = 1'b1;
    step();
    collect(-1, 0, v, n, fe, fs);
    chk("t3_bits_a", v, F9999);
    chk("t3_len_a", 64'(n), 61);
    chk("t3_b2b_valid", 64'(bf.bar_valid), 1);
    chk("t3_b2b_start", 64'(bf.frame_start), 1);
    bf.in_valid = 1'b0;
    bf.digits = 16'h0000;
    collect(-1, 0, v, n, fe, fs);
    chk("t3_bits_b", v, F9999);
    chk("t3_len_b", 64'(n), 61);

    // T4: stall at bit 20
    start(16'h1234);
    collect(20, 1, v, n, fe, fs);
    chk("t4_bits", v, F1234);
    chk("t4_len", 64'(n), 61);

    // T5: reset mid-frame at bit 30
    start(16'h1234);
    repeat (30) step();
    chk("t5_pre_valid", 64'(bf.bar_valid), 1);
    rst = 1'b1;
    #1;
    chk("t5_valid", 64'(bf.bar_valid), 0);
    chk("t5_bar", 64'(bf.bar_out), 0);
    chk("t5_busy", 64'(bf.busy), 0);
    chk("t5_ready", 64'(bf.in_ready), 1);
    chk("t5_fse", 64'({bf.frame_start, bf.frame_end}), 0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("t5_no_resume", 64'(bf.bar_valid), 0);
    start(16'h1234);
    collect(-1, 0, v, n, fe, fs);
    chk("t5_bits", v, F1234);
    chk("t5_start", 64'(fs), 1);

    // T6: in_valid pulse while busy is ignored
    start(16'h1234);
    collect(7, 2, v, n, fe, fs);
    chk("t6_bits", v, F1234);
    chk("t6_len", 64'(n), 61);
    chk("t6_after_valid", 64'(bf.bar_valid), 0);
    chk("t6_after_busy", 64'(bf.busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
